pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and a stall counter. It sits between any two pipeline stages (primarily decode→execute) and generalises the fixed-field stage latches. It adds variable control/data widths, back-pressure without combinational ready paths, bubble zeroing of control fields, and a flush for branch/exception squash.

## Interface
- CTRL_W, default 12: width of control field (write enables, ALU op, mux selects); zeroed on bubbles.
- DATA_W, default 133: width of data field (operands, immediate, PC+4, dest reg); not zeroed on bubbles.
- CNT_W, default 16: width of stall counter.
- ZERO_BUBBLE, default 1: 1 = e_ctrl forced to 0 whenever e_valid=0; 0 = e_ctrl holds last value.
- clock  in  1  rising-edge clock, single domain.
- reset  in  1  asynchronous, active-high reset.
- d_valid  in  1  upstream entry valid.
- d_ready  out  1  stage can accept; driven only from a register (no comb path from e_ready).
- d_ctrl  in  CTRL_W  upstream control field.
- d_data  in  DATA_W  upstream data field.
- flush  in  1  squash all held and incoming entries.
- e_valid  out  1  output entry valid.
- e_ready  in  1  downstream accepts.
- e_ctrl  out  CTRL_W  output control field.
- e_data  out  DATA_W  output data field.
- stall_cnt  out  CNT_W  cycles with e_valid=1 and e_ready=0, saturating.

## Operation
- Storage: output register (OUT: valid, ctrl, data) and skid register (SKID: valid, ctrl, data).
- d_ready = !SKID.valid (registered).
- accept = d_valid & d_ready; drain = !OUT.valid | e_ready.
- The following apply per rising edge, with flush taking priority:
  - flush=1: OUT.valid←0, SKID.valid←0; incoming entry discarded even if accept=1; stall_cnt unaffected.
  - drain & SKID.valid: OUT←SKID; SKID.valid←accept, and SKID←input if accept. accept is 0 here because d_ready=0.
  - drain & !SKID.valid: OUT←input, OUT.valid←accept.
  - !drain & accept: SKID←input, SKID.valid←1; OUT holds.
  - !drain & !accept: all hold.
- Order is preserved: SKID always holds the entry younger than OUT.
- No entry is ever dropped or duplicated except by flush.
- Bubble zeroing (ZERO_BUBBLE=1): whenever OUT.valid is loaded 0, OUT.ctrl is loaded 0. Downstream write enables are therefore inert without gating on e_valid.
- SKID.ctrl is not zeroed.
- stall_cnt: +1 each edge where e_valid & !e_ready & !flush; saturates at 2^CNT_W−1; cleared only by reset.

## Timing
- Reset values (asynchronous, while reset=1):
  - e_valid=0, e_ctrl=0, e_data=0, stall_cnt=0.
  - SKID valid/ctrl/data=0.
  - d_ready=1.
- Latency: entry accepted at edge N appears at e_valid/e_data after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle with e_ready held high; SKID stays empty.
- Back-pressure:
  - The first stalled cycle absorbs one extra entry into SKID.
  - d_ready falls in the following cycle.
  - d_ready rises one cycle after SKID drains.
- Full condition: OUT.valid & SKID.valid; capacity 2 entries.
- Simultaneous flush and accept: flush wins, d_ready=1 next cycle.
- Simultaneous flush and e_ready: OUT entry counts as consumed downstream and is not re-presented.
- Reset mid-operation: all in-flight entries lost; stall_cnt cleared.
- Reset deassertion: first accept is possible on the first rising edge after deassertion.

## Test plan
- Streaming: e_ready=1, drive d_data=1..8 on consecutive cycles → e_data=1..8 one cycle later, d_ready always 1, stall_cnt=0.
- Back-pressure: stream 1..6; drop e_ready for 3 cycles after entry 2 is on output → e_data holds 2, SKID takes 3, d_ready=0 for stall. Expected results:
  - stall_cnt=3.
  - After e_ready returns: 3,4,5,6 in order, no loss or duplicate.
- Flush: OUT=A, SKID=B, d_valid=1 with C, assert flush one cycle → next cycle e_valid=0, e_ctrl=0, d_ready=1; C never appears.
- Bubble zeroing: ZERO_BUBBLE=1, d_valid=0 with d_ctrl=12'hFFF → e_ctrl=0. ZERO_BUBBLE=0 variant → e_ctrl retains prior value.
- Saturation: CNT_W=4, hold e_valid=1 with e_ready=0 for 20 cycles → stall_cnt stops at 15.
- Async reset: assert reset between edges while full → outputs zero immediately. After release, first accepted entry appears one cycle later.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer. Holds up to two entries (OUT + SKID) so that d_ready can be a
// pure register output. Flush squashes everything held and incoming.
// stall_cnt counts saturating cycles where the output is valid but blocked.
module pipe_stage_skid #(
  parameter int CTRL_W      = 12,
  parameter int DATA_W      = 133,
  parameter int CNT_W       = 16,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  input  logic              flush,
  output logic              e_valid,
  input  logic              e_ready,
  output logic [CTRL_W-1:0] e_ctrl,
  output logic [DATA_W-1:0] e_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              out_valid, out_valid_nxt;
  logic [CTRL_W-1:0] out_ctrl,  out_ctrl_nxt;
  logic [DATA_W-1:0] out_data,  out_data_nxt;
  logic              skid_valid, skid_valid_nxt;
  logic [CTRL_W-1:0] skid_ctrl,  skid_ctrl_nxt;
  logic [DATA_W-1:0] skid_data,  skid_data_nxt;
  logic              d_ready_q;
  logic [CNT_W-1:0]  stall_q;

  logic accept;
  logic drain;

  assign accept = d_valid & d_ready_q;
  assign drain  = !out_valid | e_ready;

  // Next-state selection for OUT and SKID; flush has priority over all moves.
  always_comb begin
    out_valid_nxt  = out_valid;
    out_ctrl_nxt   = out_ctrl;
    out_data_nxt   = out_data;
    skid_valid_nxt = skid_valid;
    skid_ctrl_nxt  = skid_ctrl;
    skid_data_nxt  = skid_data;
    if (flush) begin
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
      if (ZERO_BUBBLE) out_ctrl_nxt = '0;
    end else if (drain) begin
      if (skid_valid) begin
        // SKID holds the older entry, so it moves to OUT first.
        out_valid_nxt  = 1'b1;
        out_ctrl_nxt   = skid_ctrl;
        out_data_nxt   = skid_data;
        skid_valid_nxt = accept;
        if (accept) begin
          skid_ctrl_nxt = d_ctrl;
          skid_data_nxt = d_data;
        end
      end else begin
        out_valid_nxt = accept;
        out_data_nxt  = d_data;
        if (accept)
          out_ctrl_nxt = d_ctrl;
        else if (ZERO_BUBBLE)
          out_ctrl_nxt = '0;
      end
    end else if (accept) begin
      skid_valid_nxt = 1'b1;
      skid_ctrl_nxt  = d_ctrl;
      skid_data_nxt  = d_data;
    end
  end

  // Entry storage; d_ready is registered as the inverse of next SKID occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      d_ready_q  <= 1'b1;
    end else begin
      out_valid  <= out_valid_nxt;
      out_ctrl   <= out_ctrl_nxt;
      out_data   <= out_data_nxt;
      skid_valid <= skid_valid_nxt;
      skid_ctrl  <= skid_ctrl_nxt;
      skid_data  <= skid_data_nxt;
      d_ready_q  <= !skid_valid_nxt;
    end
  end

  // Saturating count of blocked-output cycles; flush cycles are not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_q <= '0;
    else if (out_valid && !e_ready && !flush && stall_q != CNT_MAX)
      stall_q <= stall_q + 1'b1;
  end

  assign d_ready   = d_ready_q;
  assign e_valid   = out_valid;
  assign e_ctrl    = out_ctrl;
  assign e_data    = out_data;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: three instances share stimulus (default, ZERO_BUBBLE=0,
// CNT_W=4) so the parameter variants are checked in the same run.
module tb_pipe_stage_skid;

  logic         clock;
  logic         reset;
  logic         d_valid;
  logic [11:0]  d_ctrl;
  logic [132:0] d_data;
  logic         flush;
  logic         e_ready;

  logic         d_ready,   d_ready_nz,   d_ready_c4;
  logic         e_valid,   e_valid_nz,   e_valid_c4;
  logic [11:0]  e_ctrl,    e_ctrl_nz,    e_ctrl_c4;
  logic [132:0] e_data,    e_data_nz,    e_data_c4;
  logic [15:0]  stall_cnt, stall_cnt_nz;
  logic [3:0]   stall_cnt_c4;

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_skid dut (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_ready(d_ready),
    .d_ctrl(d_ctrl), .d_data(d_data), .flush(flush), .e_valid(e_valid),
    .e_ready(e_ready), .e_ctrl(e_ctrl), .e_data(e_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.ZERO_BUBBLE(1'b0)) dut_nz (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_ready(d_ready_nz),
    .d_ctrl(d_ctrl), .d_data(d_data), .flush(flush), .e_valid(e_valid_nz),
    .e_ready(e_ready), .e_ctrl(e_ctrl_nz), .e_data(e_data_nz), .stall_cnt(stall_cnt_nz)
  );

  pipe_stage_skid #(.CNT_W(4)) dut_c4 (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_ready(d_ready_c4),
    .d_ctrl(d_ctrl), .d_data(d_data), .flush(flush), .e_valid(e_valid_c4),
    .e_ready(e_ready), .e_ctrl(e_ctrl_c4), .e_data(e_data_c4), .stall_cnt(stall_cnt_c4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] c, input logic [132:0] d);
    d_valid = v;
    d_ctrl  = c;
    d_data  = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; e_ready = 1'b0;
    drive(1'b0, 12'h0, '0);
    #12;
    chk("rst_e_valid", e_valid, 0);
    chk("rst_e_ctrl", e_ctrl, 0);
    chk("rst_e_data", e_data, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_d_ready", d_ready, 1);
    reset = 1'b0;
    #1;

    // Streaming 1..8 with e_ready high
    e_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 12'(i), 133'(i));
      step();
      chk($sformatf("stream_v%0d", i), e_valid, 1);
      chk($sformatf("stream_d%0d", i), e_data, i);
      chk($sformatf("stream_rdy%0d", i), d_ready, 1);
    end
    chk("stream_stall", stall_cnt, 0);

    // Bubble zeroing: invalid input with all-ones ctrl
    drive(1'b0, 12'hFFF, 133'h0);
    step();
    chk("bub_valid", e_valid, 0);
    chk("bub_ctrl_z", e_ctrl, 0);
    chk("bub_ctrl_nz", e_ctrl_nz, 12'h008);
    step();
    chk("bub_ctrl_nz2", e_ctrl_nz, 12'h008);

    // Back-pressure: stream 1..6, stall for 3 cycles while 2 is on output
    drive(1'b1, 12'h1, 133'd1); step();
    drive(1'b1, 12'h2, 133'd2); step();
    chk("bp_out2", e_data, 2);
    e_ready = 1'b0;
    drive(1'b1, 12'h3, 133'd3); step();
    chk("bp_hold2a", e_data, 2);
    chk("bp_rdy_low", d_ready, 0);
    drive(1'b1, 12'h4, 133'd4); step();
    chk("bp_hold2b", e_data, 2);
    step();
    chk("bp_hold2c", e_data, 2);
    chk("bp_rdy_low2", d_ready, 0);
    chk("bp_stall3", stall_cnt, 3);
    e_ready = 1'b1;
    step();
    chk("bp_out3", e_data, 3);
    chk("bp_rdy_back", d_ready, 1);
    step();
    chk("bp_out4", e_data, 4);
    drive(1'b1, 12'h5, 133'd5); step();
    chk("bp_out5", e_data, 5);
    drive(1'b1, 12'h6, 133'd6); step();
    chk("bp_out6", e_data, 6);
    chk("bp_ctrl6", e_ctrl, 6);
    drive(1'b0, 12'h0, '0); step();
    chk("bp_empty", e_valid, 0);
    chk("bp_stall_final", stall_cnt, 3);

    // Flush with OUT=A, SKID=B and C offered
    e_ready = 1'b0;
    drive(1'b1, 12'hAAA, 133'hA); step();
    chk("fl_outA", e_data, 133'hA);
    drive(1'b1, 12'hBBB, 133'hB); step();
    chk("fl_full_rdy", d_ready, 0);
    drive(1'b1, 12'hCCC, 133'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", e_valid, 0);
    chk("fl_ctrl", e_ctrl, 0);
    chk("fl_rdy", d_ready, 1);
    chk("fl_stall", stall_cnt, 4);
    drive(1'b0, 12'h0, '0);
    e_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_noC%0d", i), e_valid, 0);
    end

    // Saturation: hold a blocked valid entry for 20 cycles
    e_ready = 1'b0;
    drive(1'b1, 12'h055, 133'h55); step();
    drive(1'b0, 12'h0, '0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_c4", stall_cnt_c4, 15);
    chk("sat_c16", stall_cnt, 24);
    chk("sat_hold", e_data, 133'h55);

    // Flush together with e_ready: entry consumed, not re-presented
    e_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fle_valid", e_valid, 0);
    chk("fle_stall", stall_cnt, 24);

    // Async reset between edges while full
    e_ready = 1'b0;
    drive(1'b1, 12'h011, 133'h11); step();
    drive(1'b1, 12'h022, 133'h22); step();
    chk("ar_full_rdy", d_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", e_valid, 0);
    chk("ar_data", e_data, 0);
    chk("ar_ctrl", e_ctrl, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_rdy", d_ready, 1);
    #1;
    reset = 1'b0;
    e_ready = 1'b1;
    drive(1'b1, 12'h033, 133'h33);
    step();
    chk("ar_first_v", e_valid, 1);
    chk("ar_first_d", e_data, 133'h33);
    drive(1'b0, 12'h0, '0);
    step();
    chk("ar_no22", e_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
